// File: rtl/move_arbiter_if.sv
// Move arbiter handshake bundle: local/remote move inputs, game_fsm
// issue/done handshake, tx start handshake and status pulses.
// The arbiter connects through the slave modport; its environment
// (user_io, rx, game_fsm, tx) connects through the master modport.
interface move_arbiter_if #(
  parameter int PKT_LEN = 8
);
  logic               my_turn;
  logic               loc_valid;
  logic [PKT_LEN-1:0] loc_move;
  logic               rem_valid;
  logic [PKT_LEN-1:0] rem_move;
  logic               move_avail;
  logic [PKT_LEN-1:0] move_out;
  logic               fsm_done;
  logic               fsm_invalid;
  logic               tx_trigger;
  logic [PKT_LEN-1:0] tx_data;
  logic               tx_busy;
  logic               busy;
  logic               loc_reject;
  logic               rem_drop;
  logic               invalid_pulse;
  logic               timeout;

  modport slave (
    input  my_turn, loc_valid, loc_move, rem_valid, rem_move,
           fsm_done, fsm_invalid, tx_busy,
    output move_avail, move_out, tx_trigger, tx_data, busy,
           loc_reject, rem_drop, invalid_pulse, timeout
  );

  modport master (
    output my_turn, loc_valid, loc_move, rem_valid, rem_move,
           fsm_done, fsm_invalid, tx_busy,
    input  move_avail, move_out, tx_trigger, tx_data, busy,
           loc_reject, rem_drop, invalid_pulse, timeout
  );
endinterface

// File: rtl/move_arbiter.sv
// Move arbiter: buffers one local and one remote move, grants one of them
// to game_fsm according to my_turn, and forwards accepted local moves to tx.
// Optional watchdog on WAIT_FSM / WAIT_TX enabled by defining
// MOVE_ARB_TIMEOUT_EN; without it those states wait indefinitely.
module move_arbiter #(
  parameter int PKT_LEN     = 8,
  parameter int TIMEOUT_CYC = 65_000_000
) (
  input  logic          clk_in,
  input  logic          rst_in,
  move_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_FSM, SEND, WAIT_TX} state_t;

  state_t             state, state_nxt;
  logic               loc_full, rem_full;
  logic [PKT_LEN-1:0] loc_buf, rem_buf, mv_reg;
  logic               grant_loc;
  logic               tx_seen;
  logic               loc_reject_q, rem_drop_q, invalid_q;
  logic               loc_load, rem_load, grant_l, grant_r;
  logic               fin, clr_loc, clr_rem, done_bad;
  logic               wd_hit;

  // A buffer only accepts a move while empty, so a granted move cannot be overwritten
  assign loc_load = bus.loc_valid & bus.my_turn & ~loc_full;
  assign rem_load = bus.rem_valid & ~rem_full;
  assign grant_l  = (state == IDLE) & loc_full & bus.my_turn;
  assign grant_r  = (state == IDLE) & rem_full & ~bus.my_turn;
  assign done_bad = (state == WAIT_FSM) & bus.fsm_done & bus.fsm_invalid;
  assign fin      = (state == WAIT_FSM) & (bus.fsm_done | wd_hit);
  assign clr_loc  = fin & grant_loc;
  assign clr_rem  = fin & ~grant_loc;

  // Outputs decoded from state so reset clears them immediately
  assign bus.busy       = (state != IDLE);
  assign bus.move_avail = (state == ISSUE);
  assign bus.move_out   = (state == ISSUE || state == WAIT_FSM) ? mv_reg : '0;
  assign bus.tx_trigger = (state == SEND) & ~bus.tx_busy;
  assign bus.tx_data    = (state == SEND || state == WAIT_TX) ? mv_reg : '0;
  assign bus.loc_reject    = loc_reject_q;
  assign bus.rem_drop      = rem_drop_q;
  assign bus.invalid_pulse = invalid_q;

`ifdef MOVE_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd;
  logic            timeout_q;
  logic            in_wait;

  // A completing fsm_done wins over an expiring watchdog in the same cycle
  assign in_wait = (state == WAIT_FSM) || (state == WAIT_TX);
  assign wd_hit  = in_wait && (wd == WD_W'(TIMEOUT_CYC - 1)) &&
                   !((state == WAIT_FSM) && bus.fsm_done);
  assign bus.timeout = timeout_q;

  // Watchdog restarts on every state entry and only counts in the wait states
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wd        <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_hit;
      if (state_nxt != state || !in_wait) wd <= '0;
      else                                wd <= wd + WD_W'(1);
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // State register, buffer flags, grant owner and status pulses
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      loc_full     <= 1'b0;
      rem_full     <= 1'b0;
      grant_loc    <= 1'b0;
      tx_seen      <= 1'b0;
      loc_reject_q <= 1'b0;
      rem_drop_q   <= 1'b0;
      invalid_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clr_loc)       loc_full <= 1'b0;
      else if (loc_load) loc_full <= 1'b1;
      if (clr_rem)       rem_full <= 1'b0;
      else if (rem_load) rem_full <= 1'b1;
      if (grant_l)       grant_loc <= 1'b1;
      else if (grant_r)  grant_loc <= 1'b0;
      tx_seen      <= (state == WAIT_TX) & (tx_seen | bus.tx_busy);
      loc_reject_q <= bus.loc_valid & ~loc_load;
      rem_drop_q   <= bus.rem_valid & ~rem_load;
      invalid_q    <= done_bad;
    end
  end

  // Move payloads; validity is carried by the flags and state, so no reset
  always_ff @(posedge clk_in) begin
    if (loc_load) loc_buf <= bus.loc_move;
    if (rem_load) rem_buf <= bus.rem_move;
    if (grant_l)      mv_reg <= loc_buf;
    else if (grant_r) mv_reg <= rem_buf;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant_l || grant_r) state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT_FSM;
      WAIT_FSM: begin
        if (bus.fsm_done) begin
          if (bus.fsm_invalid || !grant_loc) state_nxt = IDLE;
          else                               state_nxt = SEND;
        end else if (wd_hit) begin
          state_nxt = IDLE;
        end
      end
      SEND:     if (!bus.tx_busy) state_nxt = WAIT_TX;
      WAIT_TX:  if (wd_hit || (tx_seen && !bus.tx_busy)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_move_arbiter.sv
// Scoreboard bench for move_arbiter: stimulus pushes expected output events,
// a monitor pops and compares them whenever the DUT strobes an output.
module tb_move_arbiter;

  localparam int K_AVAIL = 0, K_TX = 1, K_REJ = 2, K_DROP = 3, K_INV = 4, K_TO = 5;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic clk_in;
  logic rst_in;
  logic busy_hold, busy_resp;
  int   resp_len;
  int   n_checks, n_fail;
  ev_t  expq[$];

  // abstract model of buffer occupancy
  bit         m_rem_full;
  logic [7:0] m_rem;

  move_arbiter_if #(.PKT_LEN(8)) bus ();

  move_arbiter #(.PKT_LEN(8), .TIMEOUT_CYC(100)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  assign bus.tx_busy = busy_hold | busy_resp;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic string kname(input int k);
    case (k)
      K_AVAIL: return "avail";
      K_TX:    return "tx";
      K_REJ:   return "loc_reject";
      K_DROP:  return "rem_drop";
      K_INV:   return "invalid";
      default: return "timeout";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    expq.push_back(e);
  endtask

  task automatic got(input int k, input logic [7:0] d);
    ev_t e;
    n_checks++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got data %02h, required no event", kname(k), d);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.data !== d) begin
        n_fail++;
        $display("FAIL event: got %s/%02h, required %s/%02h", kname(k), d, kname(e.kind), e.data);
      end
    end
  endtask

  // Monitor: every output strobe must match the head of the scoreboard
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (bus.move_avail)    got(K_AVAIL, bus.move_out);
      if (bus.tx_trigger)    got(K_TX, bus.tx_data);
      if (bus.loc_reject)    got(K_REJ, 8'h00);
      if (bus.rem_drop)      got(K_DROP, 8'h00);
      if (bus.invalid_pulse) got(K_INV, 8'h00);
      if (bus.timeout)       got(K_TO, 8'h00);
    end
  end

  // tx model: goes busy the cycle after a trigger for resp_len cycles
  initial begin
    busy_resp = 1'b0;
    forever begin
      @(negedge clk_in);
      if (bus.tx_trigger) begin
        @(posedge clk_in);
        #1 busy_resp = 1'b1;
        repeat (resp_len) @(posedge clk_in);
        #1 busy_resp = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "bench hung");
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_loc(input logic [7:0] v);
    bus.loc_valid = 1'b1;
    bus.loc_move  = v;
    step();
    bus.loc_valid = 1'b0;
  endtask

  task automatic pulse_rem(input logic [7:0] v);
    bus.rem_valid = 1'b1;
    bus.rem_move  = v;
    step();
    bus.rem_valid = 1'b0;
  endtask

  task automatic pulse_done(input bit inv);
    bus.fsm_done    = 1'b1;
    bus.fsm_invalid = inv;
    step();
    bus.fsm_done    = 1'b0;
    bus.fsm_invalid = 1'b0;
  endtask

  task automatic wait_avail(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk_in);
      if (bus.move_avail) found = 1'b1;
    end
  endtask

  task automatic wait_idle(input int max);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk_in);
      if (!bus.busy) found = 1'b1;
    end
    check("idle_reached", found, 1);
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_move_avail"}, bus.move_avail, 0);
    check({tag, "_move_out"}, bus.move_out, 0);
    check({tag, "_tx_trigger"}, bus.tx_trigger, 0);
    check({tag, "_tx_data"}, bus.tx_data, 0);
    check({tag, "_loc_reject"}, bus.loc_reject, 0);
    check({tag, "_rem_drop"}, bus.rem_drop, 0);
    check({tag, "_invalid"}, bus.invalid_pulse, 0);
    check({tag, "_timeout"}, bus.timeout, 0);
  endtask

  // Handle a granted move from issue to idle, with optional extra arrivals
  task automatic serve(input bit is_loc, input logic [7:0] v, input bit inv,
                       input bit xl, input bit xr, input logic [7:0] xv, input bit seen);
    bit found;
    if (!seen) begin
      wait_avail(40, found);
      check("avail_seen", found, 1);
    end
    step();
    if (xl) begin
      expect_ev(K_REJ, 8'h00);
      pulse_loc(~xv);
      step();
    end
    if (xr) begin
      if (is_loc && !m_rem_full) begin
        m_rem_full = 1'b1;
        m_rem      = xv;
      end else begin
        expect_ev(K_DROP, 8'h00);
      end
      pulse_rem(xv);
      step();
    end
    repeat ($urandom_range(0, 3)) step();
    check("move_out_hold", bus.move_out, v);
    if (inv)         expect_ev(K_INV, 8'h00);
    else if (is_loc) expect_ev(K_TX, v);
    pulse_done(inv);
    if (!is_loc) m_rem_full = 1'b0;
    wait_idle(200);
  endtask

  // Change my_turn; a held remote move is granted as soon as it is our turn to receive
  task automatic set_turn(input bit t);
    logic [7:0] held;
    if (bus.my_turn != t) begin
      bus.my_turn = t;
      if (!t && m_rem_full) begin
        held = m_rem;
        expect_ev(K_AVAIL, held);
        step();
        serve(1'b0, held, $urandom_range(0, 1) == 0, 1'b0, 1'b0, 8'h00, 1'b0);
        return;
      end
    end
    step();
  endtask

  task automatic txn(input bit is_loc, input logic [7:0] v, input bit inv,
                     input bit xl, input bit xr, input logic [7:0] xv);
    set_turn(is_loc);
    expect_ev(K_AVAIL, v);
    if (is_loc) pulse_loc(v);
    else        pulse_rem(v);
    serve(is_loc, v, inv, xl, xr, xv, 1'b0);
  endtask

  initial begin
    bit found;
    int cnt;
    n_checks = 0;
    n_fail = 0;
    m_rem_full = 1'b0;
    m_rem = 8'h00;
    resp_len = 3;
    busy_hold = 1'b0;
    rst_in = 1'b0;
    bus.my_turn = 1'b0;
    bus.loc_valid = 1'b0;
    bus.loc_move = 8'h00;
    bus.rem_valid = 1'b0;
    bus.rem_move = 8'h00;
    bus.fsm_done = 1'b0;
    bus.fsm_invalid = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_all_zero("reset");
    step();
    rst_in = 1'b1;
    step();

    // local move, issue two cycles after the input pulse
    set_turn(1'b1);
    expect_ev(K_AVAIL, 8'h35);
    pulse_loc(8'h35);
    @(negedge clk_in);
    check("latency_n1_avail", bus.move_avail, 0);
    @(negedge clk_in);
    check("latency_n2_avail", bus.move_avail, 1);
    check("latency_n2_move_out", bus.move_out, 8'h35);
    serve(1'b1, 8'h35, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("busy_after_tx", bus.busy, 0);

    // remote move, second remote arrival dropped while the buffer is full
    txn(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 8'h44);

    // invalid local move, then the emptied buffer accepts a new one
    txn(1'b1, 8'h21, 1'b1, 1'b0, 1'b0, 8'h00);
    txn(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 8'h00);

    // local move while not our turn
    set_turn(1'b0);
    expect_ev(K_REJ, 8'h00);
    pulse_loc(8'h5a);
    repeat (4) begin
      @(negedge clk_in);
      check("reject_no_avail", bus.move_avail, 0);
    end
    step();

    // tx busy at SEND delays the trigger
    set_turn(1'b1);
    expect_ev(K_AVAIL, 8'h9c);
    pulse_loc(8'h9c);
    wait_avail(40, found);
    check("hold_avail_seen", found, 1);
    step();
    busy_hold = 1'b1;
    expect_ev(K_TX, 8'h9c);
    pulse_done(1'b0);
    repeat (5) begin
      @(negedge clk_in);
      check("held_no_trigger", bus.tx_trigger, 0);
      check("held_tx_data", bus.tx_data, 8'h9c);
    end
    step();
    busy_hold = 1'b0;
    wait_idle(100);

    // watchdog
    expect_ev(K_AVAIL, 8'h77);
    pulse_loc(8'h77);
    wait_avail(40, found);
    check("wd_avail_seen", found, 1);
`ifdef MOVE_ARB_TIMEOUT_EN
    expect_ev(K_TO, 8'h00);
    cnt = 0;
    do begin
      @(negedge clk_in);
      cnt++;
    end while (!bus.timeout && cnt < 300);
    check("timeout_latency", cnt, 101);
    check("timeout_idle", bus.busy, 0);
    step();
`else
    repeat (1000) @(negedge clk_in);
    check("no_wd_still_busy", bus.busy, 1);
    check("no_wd_move_out", bus.move_out, 8'h77);
    step();
    expect_ev(K_INV, 8'h00);
    pulse_done(1'b1);
    wait_idle(50);
`endif
    txn(1'b1, 8'h3e, 1'b0, 1'b0, 1'b0, 8'h00);

    // reset in WAIT_TX aborts the transfer
    resp_len = 30;
    expect_ev(K_AVAIL, 8'hc3);
    pulse_loc(8'hc3);
    wait_avail(40, found);
    check("rst_avail_seen", found, 1);
    step();
    expect_ev(K_TX, 8'hc3);
    pulse_done(1'b0);
    cnt = 0;
    while (!bus.tx_trigger && cnt < 50) begin
      @(negedge clk_in);
      cnt++;
    end
    step();
    step();
    check("wait_tx_busy", bus.busy, 1);
    check("wait_tx_data", bus.tx_data, 8'hc3);
    rst_in = 1'b0;
    #1;
    check_all_zero("abort");
    cnt = 0;
    while (busy_resp && cnt < 100) begin
      step();
      cnt++;
    end
    step();
    rst_in = 1'b1;
    m_rem_full = 1'b0;
    resp_len = 2;
    repeat (20) step();
    txn(1'b1, 8'h0f, 1'b0, 1'b0, 1'b0, 8'h00);

    // randomized transactions, with stray fsm_done pulses while idle
    for (int i = 0; i < 40; i++) begin
      resp_len = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) pulse_done($urandom_range(0, 1) == 1);
      txn($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 8'($urandom));
    end
    set_turn(1'b0);
    repeat (10) step();
    check("scoreboard_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
